piso_tx: RTL and testbench

PISO_TX -- requirements
Module: piso_tx

---
 rtl/piso_pkg.sv | 12 +
 rtl/piso_hold_reg.sv | 45 ++++
 rtl/piso_tx.sv | 144 ++++++++++++++
 tb/tb_piso_tx.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared state encoding and default word width for the piso_tx serializer.
package piso_pkg;

    localparam int PISO_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } piso_state_t;

endpackage

// File: rtl/piso_hold_reg.sv
// One-entry holding register with full flag; buffers the next word while a frame is on the wire.
module piso_hold_reg
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             full_q, full_d;

    // A write in the same cycle as a read leaves the entry occupied by the new word.
    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (rd_en_i) begin
            full_d = 1'b0;
        end
        if (wr_en_i) begin
            data_d = wr_data_i;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign rd_data_o = data_q;
    assign full_o    = full_q;

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with one-word hold buffer for gapless frames.
// Define PISO_TX_PARITY_EN to append an even-parity bit after each word.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = PISO_WIDTH_DEFAULT,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             serial_first,
    output logic             serial_last,
    output logic             busy
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    piso_state_t      state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             accept;
    logic             last_data_bit;
    logic             frame_end;
    logic             start;
    logic [WIDTH-1:0] start_word;
    logic             hold_wr;
    logic             hold_rd;
    logic             hold_full;
    logic [WIDTH-1:0] hold_data;

`ifdef PISO_TX_PARITY_EN
    logic parity_q, parity_d;
`endif

    piso_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (hold_wr),
        .wr_data_i (parallel_in),
        .rd_en_i   (hold_rd),
        .rd_data_o (hold_data),
        .full_o    (hold_full)
    );

    assign load_ready    = !hold_full;
    assign accept        = load_valid && load_ready;
    assign last_data_bit = (state_q == SHIFT) && (cnt_q == LAST_CNT);

`ifdef PISO_TX_PARITY_EN
    assign frame_end = (state_q == PAR);
`else
    assign frame_end = last_data_bit;
`endif

    // A new frame starts from IDLE, or on the final bit cycle so frames abut without a gap.
    assign start      = ((state_q == IDLE) && accept) || (frame_end && (hold_full || accept));
    assign start_word = (frame_end && hold_full) ? hold_data : parallel_in;
    assign hold_rd    = frame_end && hold_full;
    assign hold_wr    = accept && (state_q != IDLE) && !frame_end;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
`ifdef PISO_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            SHIFT: begin
                shift_d = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);
                cnt_d   = cnt_q + 1'b1;
                if (last_data_bit) begin
                    cnt_d = '0;
`ifdef PISO_TX_PARITY_EN
                    state_d = PAR;
`endif
                end
            end
            default: ;
        endcase

        if (start) begin
            state_d = SHIFT;
            shift_d = start_word;
            cnt_d   = '0;
`ifdef PISO_TX_PARITY_EN
            parity_d = ^start_word;
`endif
        end else if (frame_end) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PISO_TX_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    // Outputs decode only registered state, so they never depend on this cycle's inputs.
    always_comb begin
        serial_out   = 1'b0;
        serial_valid = 1'b0;
        serial_first = 1'b0;
        serial_last  = frame_end;
        if (state_q == SHIFT) begin
            serial_out   = (MSB_FIRST != 0) ? shift_q[WIDTH-1] : shift_q[0];
            serial_valid = 1'b1;
            serial_first = (cnt_q == '0);
        end
`ifdef PISO_TX_PARITY_EN
        if (state_q == PAR) begin
            serial_out   = parity_q;
            serial_valid = 1'b1;
        end
`endif
    end

    assign busy = (state_q != IDLE) || hold_full;

endmodule

// File: tb/tb_piso_tx.sv
// Directed self-checking bench for piso_tx; checks adapt when PISO_TX_PARITY_EN is defined.
module tb_piso_tx;

`ifdef PISO_TX_PARITY_EN
    localparam int PBIT = 1;
`else
    localparam int PBIT = 0;
`endif
    localparam int FL = 4 + PBIT;

    logic       clk         = 1'b0;
    logic       reset       = 1'b1;
    logic [3:0] parallel_in = 4'h0;
    logic       load_valid  = 1'b0;

    logic m_ready, m_out, m_valid, m_first, m_last, m_busy;
    logic l_ready, l_out, l_valid, l_first, l_last, l_busy;

    int total_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(4), .MSB_FIRST(1)) dut_m (
        .clk          (clk),
        .reset        (reset),
        .parallel_in  (parallel_in),
        .load_valid   (load_valid),
        .load_ready   (m_ready),
        .serial_out   (m_out),
        .serial_valid (m_valid),
        .serial_first (m_first),
        .serial_last  (m_last),
        .busy         (m_busy)
    );

    piso_tx #(.WIDTH(4), .MSB_FIRST(0)) dut_l (
        .clk          (clk),
        .reset        (reset),
        .parallel_in  (parallel_in),
        .load_valid   (load_valid),
        .load_ready   (l_ready),
        .serial_out   (l_out),
        .serial_valid (l_valid),
        .serial_first (l_first),
        .serial_last  (l_last),
        .busy         (l_busy)
    );

    function automatic logic exp_bit(input logic [3:0] w, input int pos, input bit msb);
        if (pos >= 4) return ^w;
        return msb ? w[3-pos] : w[pos];
    endfunction

    task automatic test_reset();
        logic [5:0] got;
        #1 reset = 1'b0;
        @(negedge clk);
        got = {m_valid, m_first, m_last, m_out, m_busy, m_ready};
        total_cnt++;
        if (got !== 6'b000001) $display("FAIL reset_por_msb: got %b expected %b", got, 6'b000001);
        else pass_cnt++;
        got = {l_valid, l_first, l_last, l_out, l_busy, l_ready};
        total_cnt++;
        if (got !== 6'b000001) $display("FAIL reset_por_lsb: got %b expected %b", got, 6'b000001);
        else pass_cnt++;
        $display("tb: power-on reset released");
        reset       = 1'b1;
        load_valid  = 1'b1;
        parallel_in = 4'hF;
        @(negedge clk);
        parallel_in = 4'h6;
        @(negedge clk);
        load_valid = 1'b0;
        total_cnt++;
        if ({m_valid, m_ready, m_busy} !== 3'b101)
            $display("FAIL reset_preframe: got %b expected %b", {m_valid, m_ready, m_busy}, 3'b101);
        else pass_cnt++;
        #1 reset = 1'b0;
        #1;
        got = {m_valid, m_first, m_last, m_out, m_busy, m_ready};
        total_cnt++;
        if (got !== 6'b000001) $display("FAIL reset_midframe: got %b expected %b", got, 6'b000001);
        else pass_cnt++;
        $display("tb: reset asserted mid-frame with word pending");
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < FL + 2; i++) begin
            @(negedge clk);
            total_cnt++;
            if ({m_valid, m_busy, m_out} !== 3'b000)
                $display("FAIL reset_noresume cyc%0d: got %b expected %b", i, {m_valid, m_busy, m_out}, 3'b000);
            else pass_cnt++;
        end
    endtask

    task automatic test_single_msb();
        logic [0:3] seq;
        logic [3:0] exp;
        seq         = 4'b0010;
        load_valid  = 1'b1;
        parallel_in = 4'b0010;
        @(negedge clk);
        load_valid = 1'b0;
        $display("tb: single msb-first word 0010");
        for (int i = 0; i < 4; i++) begin
            exp = {1'b1, i == 0, (i == 3) && (PBIT == 0), seq[i]};
            total_cnt++;
            if ({m_valid, m_first, m_last, m_out} !== exp)
                $display("FAIL single_msb bit%0d: got %b expected %b", i, {m_valid, m_first, m_last, m_out}, exp);
            else pass_cnt++;
            @(negedge clk);
        end
`ifdef PISO_TX_PARITY_EN
        total_cnt++;
        if ({m_valid, m_first, m_last, m_out} !== 4'b1011)
            $display("FAIL single_msb parity: got %b expected %b", {m_valid, m_first, m_last, m_out}, 4'b1011);
        else pass_cnt++;
        @(negedge clk);
`endif
        total_cnt++;
        if ({m_valid, m_first, m_last, m_out, m_busy} !== 5'b00000)
            $display("FAIL single_msb idle: got %b expected %b", {m_valid, m_first, m_last, m_out, m_busy}, 5'b00000);
        else pass_cnt++;
    endtask

    task automatic test_lsb_first();
        logic [0:3] seq;
        logic [3:0] exp;
        seq         = 4'b1011;
        load_valid  = 1'b1;
        parallel_in = 4'b1101;
        @(negedge clk);
        load_valid = 1'b0;
        $display("tb: single lsb-first word 1101");
        for (int i = 0; i < 4; i++) begin
            exp = {1'b1, i == 0, (i == 3) && (PBIT == 0), seq[i]};
            total_cnt++;
            if ({l_valid, l_first, l_last, l_out} !== exp)
                $display("FAIL lsb_first bit%0d: got %b expected %b", i, {l_valid, l_first, l_last, l_out}, exp);
            else pass_cnt++;
            @(negedge clk);
        end
`ifdef PISO_TX_PARITY_EN
        total_cnt++;
        if ({l_valid, l_first, l_last, l_out} !== 4'b1011)
            $display("FAIL lsb_first parity: got %b expected %b", {l_valid, l_first, l_last, l_out}, 4'b1011);
        else pass_cnt++;
        @(negedge clk);
`endif
        total_cnt++;
        if ({l_valid, l_busy} !== 2'b00)
            $display("FAIL lsb_first idle: got %b expected %b", {l_valid, l_busy}, 2'b00);
        else pass_cnt++;
    endtask

`ifdef PISO_TX_PARITY_EN
    task automatic test_parity();
        logic [0:4] seq;
        logic [3:0] exp;
        seq         = 5'b01111;
        load_valid  = 1'b1;
        parallel_in = 4'b0111;
        @(negedge clk);
        load_valid = 1'b0;
        $display("tb: parity frame word 0111");
        for (int i = 0; i < 5; i++) begin
            exp = {1'b1, i == 0, i == 4, seq[i]};
            total_cnt++;
            if ({m_valid, m_first, m_last, m_out} !== exp)
                $display("FAIL parity bit%0d: got %b expected %b", i, {m_valid, m_first, m_last, m_out}, exp);
            else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++;
        if (m_valid !== 1'b0) $display("FAIL parity idle: got %b expected %b", m_valid, 1'b0);
        else pass_cnt++;
    endtask
`endif

    task automatic test_back_to_back();
        logic [3:0] words [3];
        logic [3:0] exp;
        logic       exp_ready;
        int         idx;
        int         f;
        int         pos;
        bit         acc;
        words       = '{4'hA, 4'h5, 4'hF};
        idx         = 0;
        load_valid  = 1'b1;
        parallel_in = words[0];
        for (int k = 1; k <= 3 * FL + 1; k++) begin
            acc = load_valid && m_ready;
            @(negedge clk);
            if (k <= 3 * FL) begin
                f         = (k - 1) / FL;
                pos       = (k - 1) % FL;
                exp       = {1'b1, pos == 0, pos == FL - 1, exp_bit(words[f], pos, 1'b1)};
                exp_ready = (k > 2 * FL) || (pos == 0);
                total_cnt++;
                if ({m_valid, m_first, m_last, m_out} !== exp)
                    $display("FAIL b2b serial k%0d: got %b expected %b", k, {m_valid, m_first, m_last, m_out}, exp);
                else pass_cnt++;
                total_cnt++;
                if (m_ready !== exp_ready)
                    $display("FAIL b2b ready k%0d: got %b expected %b", k, m_ready, exp_ready);
                else pass_cnt++;
            end else begin
                total_cnt++;
                if ({m_valid, m_busy} !== 2'b00)
                    $display("FAIL b2b idle: got %b expected %b", {m_valid, m_busy}, 2'b00);
                else pass_cnt++;
            end
            if (acc) begin
                $display("tb: back_to_back word %h accepted", words[idx]);
                idx++;
                if (idx < 3) parallel_in = words[idx];
                else load_valid = 1'b0;
            end
        end
    endtask

    task automatic test_gapless();
        logic [3:0] exp;
        load_valid  = 1'b1;
        parallel_in = 4'h3;
        @(negedge clk);
        load_valid = 1'b0;
        $display("tb: gapless word 3 then word C on last bit");
        for (int i = 0; i < FL; i++) begin
            exp = {1'b1, i == 0, i == FL - 1, exp_bit(4'h3, i, 1'b1)};
            total_cnt++;
            if ({m_valid, m_first, m_last, m_out} !== exp)
                $display("FAIL gapless first bit%0d: got %b expected %b", i, {m_valid, m_first, m_last, m_out}, exp);
            else pass_cnt++;
            if (i == FL - 1) begin
                total_cnt++;
                if (m_ready !== 1'b1) $display("FAIL gapless ready: got %b expected %b", m_ready, 1'b1);
                else pass_cnt++;
                load_valid  = 1'b1;
                parallel_in = 4'hC;
            end
            @(negedge clk);
        end
        load_valid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            exp = {1'b1, i == 0, i == FL - 1, exp_bit(4'hC, i, 1'b1)};
            total_cnt++;
            if ({m_valid, m_first, m_last, m_out} !== exp)
                $display("FAIL gapless second bit%0d: got %b expected %b", i, {m_valid, m_first, m_last, m_out}, exp);
            else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++;
        if ({m_valid, m_busy} !== 2'b00)
            $display("FAIL gapless idle: got %b expected %b", {m_valid, m_busy}, 2'b00);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_msb();
        test_lsb_first();
`ifdef PISO_TX_PARITY_EN
        test_parity();
`endif
        test_back_to_back();
        test_gapless();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
